// File: rtl/score_display_pkg.sv
// Shared constants, FSM state type and helpers for the score display path.
package score_display_pkg;

   localparam int unsigned BCD_W       = 4;
   localparam int unsigned ADD3_THRESH = 5;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_e;

   // Largest value representable in num_digits decimal digits.
   function automatic int unsigned max_val(input int unsigned num_digits);
      int unsigned v;
      v = 1;
      for (int unsigned i = 0; i < num_digits; i++) begin
         v = v * 10;
      end
      return v - 1;
   endfunction

endpackage

// File: rtl/bcd_add3_digit.sv
// Double-dabble digit correction: add 3 to a BCD digit that is 5 or more.
module bcd_add3_digit
   import score_display_pkg::*;
(
   input  logic [BCD_W-1:0] digit_in,
   output logic [BCD_W-1:0] digit_out
);

   always_comb begin
      if (digit_in >= BCD_W'(ADD3_THRESH)) begin
         digit_out = digit_in + BCD_W'(3);
      end else begin
         digit_out = digit_in;
      end
   end

endmodule

// File: rtl/score_bcd_converter.sv
// Sequential binary-to-BCD score converter: reconverts on every score change and holds
// registered digits, saturating to all nines above the displayable range.
module score_bcd_converter
   import score_display_pkg::*;
#(
   parameter int unsigned BIN_WIDTH  = 32,
   parameter int unsigned NUM_DIGITS = 3
) (
   input  logic                        clock,
   input  logic                        reset,
   input  logic [BIN_WIDTH-1:0]        score_in,
   output logic [BCD_W*NUM_DIGITS-1:0] digits_out,
   output logic                        digit_valid,
   output logic                        busy,
   output logic                        overflow
);

   localparam int unsigned BCD_SR_W = BCD_W * NUM_DIGITS;
   localparam int unsigned CNT_W    = $clog2(BIN_WIDTH);
   localparam int unsigned MAX_VAL  = max_val(NUM_DIGITS);
   // Widened so the saturation compare works for any BIN_WIDTH.
   localparam logic [BIN_WIDTH+31:0] MAX_EXT   = (BIN_WIDTH + 32)'(MAX_VAL);
   localparam logic [CNT_W-1:0]      CNT_LAST  = CNT_W'(BIN_WIDTH - 1);
   localparam logic [BCD_SR_W-1:0]   ALL_NINES = {NUM_DIGITS{4'h9}};

   state_e                 state_q, state_d;
   logic [BIN_WIDTH-1:0]   bin_sr_q, bin_sr_d;
   logic [BIN_WIDTH-1:0]   last_val_q, last_val_d;
   logic [BCD_SR_W-1:0]    bcd_sr_q, bcd_sr_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic                   sat_q, sat_d;
   logic [BCD_SR_W-1:0]    digits_q, digits_d;
   logic                   valid_q, valid_d;
   logic                   busy_q, busy_d;
   logic                   ovf_q, ovf_d;

   logic [BCD_SR_W-1:0]    bcd_corr;
   logic                   saturating;
   logic                   unused_carry;

   for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
      bcd_add3_digit u_add3 (
         .digit_in  (bcd_sr_q[g*BCD_W +: BCD_W]),
         .digit_out (bcd_corr[g*BCD_W +: BCD_W])
      );
   end

   // The top corrected bit is shifted out; it is always 0 for in-range values.
   assign unused_carry = bcd_corr[BCD_SR_W-1];
   assign saturating   = {32'd0, score_in} > MAX_EXT;

   always_comb begin
      state_d    = state_q;
      bin_sr_d   = bin_sr_q;
      last_val_d = last_val_q;
      bcd_sr_d   = bcd_sr_q;
      cnt_d      = cnt_q;
      sat_d      = sat_q;
      digits_d   = digits_q;
      valid_d    = 1'b0;
      busy_d     = busy_q;
      ovf_d      = ovf_q;

      case (state_q)
         IDLE: begin
            if (score_in != last_val_q) begin
               last_val_d = score_in;
               bin_sr_d   = score_in;
               if (saturating) begin
                  sat_d   = 1'b1;
                  state_d = DONE;
               end else begin
                  sat_d    = 1'b0;
                  bcd_sr_d = '0;
                  cnt_d    = '0;
                  busy_d   = 1'b1;
                  state_d  = SHIFT;
               end
            end
         end
         SHIFT: begin
            bcd_sr_d = {bcd_corr[BCD_SR_W-2:0], bin_sr_q[BIN_WIDTH-1]};
            bin_sr_d = {bin_sr_q[BIN_WIDTH-2:0], 1'b0};
            cnt_d    = cnt_q + 1'b1;
            if (cnt_q == CNT_LAST) begin
               state_d = DONE;
            end
         end
         DONE: begin
            digits_d = sat_q ? ALL_NINES : bcd_sr_q;
            ovf_d    = sat_q;
            valid_d  = 1'b1;
            busy_d   = 1'b0;
            state_d  = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= IDLE;
         bin_sr_q   <= '0;
         last_val_q <= '0;
         bcd_sr_q   <= '0;
         cnt_q      <= '0;
         sat_q      <= 1'b0;
         digits_q   <= '0;
         valid_q    <= 1'b0;
         busy_q     <= 1'b0;
         ovf_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         bin_sr_q   <= bin_sr_d;
         last_val_q <= last_val_d;
         bcd_sr_q   <= bcd_sr_d;
         cnt_q      <= cnt_d;
         sat_q      <= sat_d;
         digits_q   <= digits_d;
         valid_q    <= valid_d;
         busy_q     <= busy_d;
         ovf_q      <= ovf_d;
      end
   end

   assign digits_out  = digits_q;
   assign digit_valid = valid_q;
   assign busy        = busy_q;
   assign overflow    = ovf_q;

endmodule

// File: tb/tb_score_bcd_converter.sv
// Randomized self-checking bench for score_bcd_converter against a decimal reference model.
module tb_score_bcd_converter;

   localparam int LAT_CONV = 34;   // ticks from input change to visible pulse (edge N+33)
   localparam int LAT_SAT  = 2;    // saturated path (edge N+1)
   localparam int BOUND    = 120;

   logic        clock = 1'b0;
   logic        reset;
   logic [31:0] score_in;
   logic [11:0] digits_out;
   logic        digit_valid;
   logic        busy;
   logic        overflow;

   int          n_vec = 0;
   int          n_err = 0;
   logic [31:0] last_set = '0;

   score_bcd_converter #(
      .BIN_WIDTH  (32),
      .NUM_DIGITS (3)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .score_in    (score_in),
      .digits_out  (digits_out),
      .digit_valid (digit_valid),
      .busy        (busy),
      .overflow    (overflow)
   );

   always #5 clock = ~clock;

   // Decimal model: clamp to 999, split with /10 and %10.
   function automatic logic [11:0] ref_bcd(input logic [31:0] v);
      int unsigned c;
      logic [11:0] r;
      c = (v > 32'd999) ? 999 : int'(v);
      r = {4'(c / 100), 4'((c / 10) % 10), 4'(c % 10)};
      return r;
   endfunction

   function automatic logic ref_ovf(input logic [31:0] v);
      return v > 32'd999;
   endfunction

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic apply(input logic [31:0] v);
      score_in = v;
      last_set = v;
   endtask

   // Waits for a digit_valid pulse; reports ticks taken and busy after the first tick.
   task automatic wait_valid(output int k_out, output bit seen, output logic busy1);
      seen  = 1'b0;
      k_out = -1;
      busy1 = 1'b0;
      for (int k = 1; k <= BOUND && !seen; k++) begin
         tick();
         if (k == 1) busy1 = busy;
         if (digit_valid) begin
            seen  = 1'b1;
            k_out = k;
         end
      end
   endtask

   task automatic count_pulses(input int cycles, output int n);
      n = 0;
      for (int k = 0; k < cycles; k++) begin
         tick();
         if (digit_valid) n++;
      end
   endtask

   task automatic test_reset();
      int n;
      reset = 1'b1;
      score_in = '0;
      last_set = '0;
      repeat (3) tick();
      n_vec++; if (digits_out !== 12'h000) begin n_err++; $display("FAIL reset_digits got %h want 000", digits_out); end
      n_vec++; if (digit_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b want 0", digit_valid); end
      n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
      n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL reset_ovf got %b want 0", overflow); end
      reset = 1'b0;
      count_pulses(10, n);
      n_vec++; if (n !== 0) begin n_err++; $display("FAIL reset_no_pulse got %0d pulses want 0", n); end
   endtask

   task automatic test_single();
      int   k;
      bit   seen;
      logic b1;
      apply(32'd7);
      wait_valid(k, seen, b1);
      n_vec++; if (b1 !== 1'b1) begin n_err++; $display("FAIL single_busy got %b want 1", b1); end
      n_vec++; if (k !== LAT_CONV) begin n_err++; $display("FAIL single_latency got %0d want %0d", k, LAT_CONV); end
      n_vec++; if (digits_out !== 12'h007) begin n_err++; $display("FAIL single_digits got %h want 007", digits_out); end
      tick();
      n_vec++; if (digit_valid !== 1'b0) begin n_err++; $display("FAIL single_pulse_width got %b want 0", digit_valid); end
      n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL single_busy_end got %b want 0", busy); end
   endtask

   task automatic test_sequence();
      logic [31:0] vals [2];
      int   k, n;
      bit   seen;
      logic b1;
      vals[0] = 32'd123;
      vals[1] = 32'd999;
      for (int i = 0; i < 2; i++) begin
         apply(vals[i]);
         wait_valid(k, seen, b1);
         n_vec++; if (k !== LAT_CONV) begin n_err++; $display("FAIL seq_latency[%0d] got %0d want %0d", i, k, LAT_CONV); end
         n_vec++; if (digits_out !== ref_bcd(vals[i])) begin n_err++; $display("FAIL seq_digits[%0d] got %h want %h", i, digits_out, ref_bcd(vals[i])); end
         n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL seq_ovf[%0d] got %b want 0", i, overflow); end
         count_pulses(40, n);
         n_vec++; if (n !== 0) begin n_err++; $display("FAIL seq_extra_pulses[%0d] got %0d want 0", i, n); end
      end
   endtask

   task automatic test_saturate();
      int   k, n;
      bit   seen;
      logic b1;
      apply(32'd1000);
      wait_valid(k, seen, b1);
      n_vec++; if (k !== LAT_SAT) begin n_err++; $display("FAIL sat_latency got %0d want %0d", k, LAT_SAT); end
      n_vec++; if (digits_out !== 12'h999) begin n_err++; $display("FAIL sat_digits got %h want 999", digits_out); end
      n_vec++; if (overflow !== 1'b1) begin n_err++; $display("FAIL sat_ovf got %b want 1", overflow); end
      apply(32'd1000);
      count_pulses(40, n);
      n_vec++; if (n !== 0) begin n_err++; $display("FAIL sat_repeat_pulses got %0d want 0", n); end
      apply(32'd42);
      wait_valid(k, seen, b1);
      n_vec++; if (k !== LAT_CONV) begin n_err++; $display("FAIL unsat_latency got %0d want %0d", k, LAT_CONV); end
      n_vec++; if (digits_out !== 12'h042) begin n_err++; $display("FAIL unsat_digits got %h want 042", digits_out); end
      n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL unsat_ovf got %b want 0", overflow); end
   endtask

   task automatic test_back_to_back();
      logic [11:0] got [$];
      apply(32'd5);
      for (int k = 0; k < 100; k++) begin
         tick();
         if (k == 9) apply(32'd88);
         if (digit_valid) got.push_back(digits_out);
      end
      n_vec++; if (got.size() !== 2) begin n_err++; $display("FAIL b2b_pulse_count got %0d want 2", got.size()); end
      n_vec++; if (got.size() < 1 || got[0] !== 12'h005) begin n_err++; $display("FAIL b2b_first got %h want 005", (got.size() > 0) ? got[0] : 12'hxxx); end
      n_vec++; if (got.size() < 2 || got[1] !== 12'h088) begin n_err++; $display("FAIL b2b_second got %h want 088", (got.size() > 1) ? got[1] : 12'hxxx); end
      n_vec++; if (digits_out !== 12'h088) begin n_err++; $display("FAIL b2b_final got %h want 088", digits_out); end
   endtask

   task automatic test_reset_mid();
      int   k;
      bit   seen;
      logic b1;
      apply(32'd250);
      repeat (10) tick();
      n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL mid_busy got %b want 1", busy); end
      reset = 1'b1;
      tick();
      n_vec++; if (digits_out !== 12'h000) begin n_err++; $display("FAIL mid_reset_digits got %h want 000", digits_out); end
      n_vec++; if ({digit_valid, busy, overflow} !== 3'b000) begin n_err++; $display("FAIL mid_reset_flags got %b want 000", {digit_valid, busy, overflow}); end
      reset = 1'b0;
      wait_valid(k, seen, b1);
      n_vec++; if (k !== LAT_CONV) begin n_err++; $display("FAIL mid_reconv_latency got %0d want %0d", k, LAT_CONV); end
      n_vec++; if (digits_out !== 12'h250) begin n_err++; $display("FAIL mid_reconv_digits got %h want 250", digits_out); end
   endtask

   task automatic test_random();
      logic [31:0] dir [5];
      logic [31:0] v;
      int   k;
      bit   seen;
      logic b1;
      dir[0] = 32'd0;
      dir[1] = 32'd999;
      dir[2] = 32'd1000;
      dir[3] = 32'd998;
      dir[4] = 32'hFFFF_FFFF;
      for (int i = 0; i < 29; i++) begin
         if (i < 5) v = dir[i];
         else if ($urandom_range(0, 3) == 0) v = $urandom;
         else v = 32'($urandom_range(0, 999));
         if (v == last_set) v = v ^ 32'd1;
         apply(v);
         wait_valid(k, seen, b1);
         n_vec++; if (k !== (ref_ovf(v) ? LAT_SAT : LAT_CONV)) begin n_err++; $display("FAIL rand_latency v=%0d got %0d want %0d", v, k, ref_ovf(v) ? LAT_SAT : LAT_CONV); end
         n_vec++; if (digits_out !== ref_bcd(v)) begin n_err++; $display("FAIL rand_digits v=%0d got %h want %h", v, digits_out, ref_bcd(v)); end
         n_vec++; if (overflow !== ref_ovf(v)) begin n_err++; $display("FAIL rand_ovf v=%0d got %b want %b", v, overflow, ref_ovf(v)); end
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_sequence();
      test_saturate();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
